decode_issue_controller: RTL and testbench
==========================================

DECODE_ISSUE_CONTROLLER -- requirements
Module: decode_issue_controller

Interface
REQ-001 Parameter REGISTER_INDEX_WIDTH, default 5, register index width (RIW).
REQ-002 Parameter MUL_LATENCY, default 5, execute cycles occupied by a multiply; legal range 2..16.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 dec_valid  input  1  decode stage holds a valid instruction.
REQ-006 dec_src1, dec_src2  input  RIW each  source register indices of the decode instruction.
REQ-007 dec_uses_src1, dec_uses_src2  input  1 each  corresponding source is actually read.
REQ-008 dec_is_mul  input  1  decode instruction is a multiply.
REQ-009 ex_dst_reg  input  RIW  destination index held in the decode/execute register.
REQ-010 ex_is_load  input  1  instruction in execute is a d-cache read.
REQ-011 mem_stall_in  input  1  data cache miss pending; pipeline must freeze.
REQ-012 branch_taken  input  1  branch resolved taken in execute this cycle.
REQ-013 stall_out  output  1  drives decode/execute register stall input and fetch/decode hold.
REQ-014 set_nop_out  output  1  drives decode/execute register NOP injection.
REQ-015 execution_empty_out  output  1  execute stage may accept a new instruction.
REQ-016 state_out  output  2  current FSM state, debug only.

Function
REQ-017 FSM states SHALL be RUN=2'd0, MUL=2'd1, MEM=2'd2, FLUSH=2'd3, held in state_out.
REQ-018 Outputs SHALL be combinational from state, counter and inputs, so they are stable before the decode/execute register samples on negedge clk.
REQ-019 Hazard SHALL be: dec_valid & ex_is_load & ex_dst_reg!=0 & ((dec_uses_src1 & dec_src1==ex_dst_reg) | (dec_uses_src2 & dec_src2==ex_dst_reg)); register 0 never creates a hazard.
REQ-020 In RUN, priority SHALL be mem_stall_in > branch_taken > hazard > multiply issue.
REQ-021 RUN, mem_stall_in=1: stall_out=1, set_nop_out=0, execution_empty_out=0; next state MEM.
REQ-022 RUN, branch_taken=1: set_nop_out=1, stall_out=0; next state FLUSH.
REQ-023 RUN, hazard: stall_out=1, set_nop_out=1 for exactly that cycle; state stays RUN.
REQ-024 RUN, dec_valid & dec_is_mul, no higher-priority event: instruction issues (all control outputs 0); next state MUL, counter loaded MUL_LATENCY-1.
REQ-025 RUN otherwise: stall_out=0, set_nop_out=0, execution_empty_out=1.
REQ-026 MUL: stall_out=1, set_nop_out=0, execution_empty_out=0; counter decrements each posedge unless mem_stall_in=1 (counter holds); transition to RUN on the posedge where counter==1 and mem_stall_in=0.
REQ-027 MEM: stall_out=1, execution_empty_out=0, set_nop_out=0; return to RUN on first posedge with mem_stall_in=0.
REQ-028 FLUSH: set_nop_out=1, stall_out=0, execution_empty_out=1 for one cycle, then RUN; mem_stall_in=1 in FLUSH holds FLUSH with stall_out=1.
REQ-029 branch_taken SHALL be ignored outside RUN; execute holds it while frozen.
REQ-030 dec_valid=0 SHALL suppress hazard and multiply issue.
REQ-031 set_nop_out and stall_out SHALL never both be 1 except in the hazard cycle (REQ-023).
REQ-032 Counter width SHALL be 4 bits; it never wraps below 1 while in MUL.

Reset
REQ-033 rst_n=0 SHALL immediately force state RUN and counter 0, independent of clk.
REQ-034 While rst_n=0: stall_out=0, set_nop_out=1, execution_empty_out=1.
REQ-035 Reset mid-MUL/MEM/FLUSH SHALL abort the operation; the first posedge after rst_n rises evaluates RUN rules.

Verification
REQ-036 Load r3 in execute, decode reads r3 via src2 -> one cycle stall_out=1, set_nop_out=1, then RUN with stall_out=0.
REQ-037 Load r0 in execute, decode reads r0 -> no stall, no NOP.
REQ-038 MUL issued, MUL_LATENCY=5 -> stall_out=1 for 4 cycles, state_out=1, then RUN; mem_stall_in pulsed 2 cycles mid-MUL -> stall lasts 6 cycles.
REQ-039 branch_taken in RUN -> set_nop_out=1 for 2 consecutive cycles (RUN then FLUSH), state_out 0->3->0.
REQ-040 mem_stall_in and branch_taken together in RUN -> MEM entered, branch ignored until return to RUN, then FLUSH sequence.
REQ-041 rst_n low during MUL with counter=3 -> state_out=0, set_nop_out=1 without a clock edge; after release, idle outputs stall_out=0, set_nop_out=0.

Source files
------------

// File: rtl/decode_issue_controller.sv
// Decode/issue pipeline controller.
// Generates the stall, NOP-injection and execute-availability controls for the
// decode/execute register. The controls are purely combinational from the FSM
// state, the multiply counter and the current inputs. This keeps them settled
// before the decode/execute register samples on the falling clock edge.
module decode_issue_controller #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int MUL_LATENCY          = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dec_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] dec_src1,
  input  logic [REGISTER_INDEX_WIDTH-1:0] dec_src2,
  input  logic                            dec_uses_src1,
  input  logic                            dec_uses_src2,
  input  logic                            dec_is_mul,
  input  logic [REGISTER_INDEX_WIDTH-1:0] ex_dst_reg,
  input  logic                            ex_is_load,
  input  logic                            mem_stall_in,
  input  logic                            branch_taken,
  output logic                            stall_out,
  output logic                            set_nop_out,
  output logic                            execution_empty_out,
  output logic [1:0]                      state_out
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MUL   = 2'd1,
    MEM   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // The multiply occupies execute for MUL_LATENCY cycles. The issue cycle
  // itself is the first of those cycles, so the counter covers the remainder.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hazard;

  // A load-use hazard exists when decode reads the register that the load in
  // execute is about to write. Register 0 is hardwired, so it never conflicts.
  assign hazard = dec_valid & ex_is_load & (ex_dst_reg != '0) &
                  ((dec_uses_src1 & (dec_src1 == ex_dst_reg)) |
                   (dec_uses_src2 & (dec_src2 == ex_dst_reg)));

  assign state_out = state_q;

  // State and multiply counter registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and control outputs. Reset forces a NOP into execute.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    stall_out           = 1'b0;
    set_nop_out         = 1'b0;
    execution_empty_out = 1'b1;

    case (state_q)
      RUN: begin
        if (mem_stall_in) begin
          stall_out           = 1'b1;
          execution_empty_out = 1'b0;
          state_d             = MEM;
        end else if (branch_taken) begin
          set_nop_out = 1'b1;
          state_d     = FLUSH;
        end else if (hazard) begin
          // Hold decode and place a bubble in execute for one cycle only.
          stall_out   = 1'b1;
          set_nop_out = 1'b1;
        end else if (dec_valid && dec_is_mul) begin
          execution_empty_out = 1'b0;
          state_d             = MUL;
          cnt_d               = MUL_CNT_INIT;
        end
      end

      MUL: begin
        stall_out           = 1'b1;
        execution_empty_out = 1'b0;
        // A cache miss freezes the whole pipeline, including the multiplier.
        if (!mem_stall_in) begin
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      MEM: begin
        stall_out           = 1'b1;
        execution_empty_out = 1'b0;
        if (!mem_stall_in) begin
          state_d = RUN;
        end
      end

      FLUSH: begin
        if (mem_stall_in) begin
          // The flush is deferred until the miss resolves. Meanwhile the
          // whole pipeline is frozen.
          stall_out           = 1'b1;
          execution_empty_out = 1'b0;
        end else begin
          set_nop_out = 1'b1;
          state_d     = RUN;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase

    if (!rst_n) begin
      stall_out           = 1'b0;
      set_nop_out         = 1'b1;
      execution_empty_out = 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_controller.sv
// Directed testbench for decode_issue_controller with hand-computed expectations.
module tb_decode_issue_controller;

  logic       clk;
  logic       rst_n;
  logic       dec_valid;
  logic [4:0] dec_src1;
  logic [4:0] dec_src2;
  logic       dec_uses_src1;
  logic       dec_uses_src2;
  logic       dec_is_mul;
  logic [4:0] ex_dst_reg;
  logic       ex_is_load;
  logic       mem_stall_in;
  logic       branch_taken;
  logic       stall_out;
  logic       set_nop_out;
  logic       execution_empty_out;
  logic [1:0] state_out;

  int checks;
  int failures;

  decode_issue_controller #(
    .REGISTER_INDEX_WIDTH(5),
    .MUL_LATENCY(5)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dec_valid           (dec_valid),
    .dec_src1            (dec_src1),
    .dec_src2            (dec_src2),
    .dec_uses_src1       (dec_uses_src1),
    .dec_uses_src2       (dec_uses_src2),
    .dec_is_mul          (dec_is_mul),
    .ex_dst_reg          (ex_dst_reg),
    .ex_is_load          (ex_is_load),
    .mem_stall_in        (mem_stall_in),
    .branch_taken        (branch_taken),
    .stall_out           (stall_out),
    .set_nop_out         (set_nop_out),
    .execution_empty_out (execution_empty_out),
    .state_out           (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare state and all three controls; inputs are settled beforehand.
  task automatic chk_outs(input string tag, input logic [1:0] st, input logic stall,
                          input logic nop, input logic empty);
    #1;
    check({tag, ".state"}, 32'(state_out), 32'(st));
    check({tag, ".stall"}, 32'(stall_out), 32'(stall));
    check({tag, ".nop"},   32'(set_nop_out), 32'(nop));
    check({tag, ".empty"}, 32'(execution_empty_out), 32'(empty));
  endtask

  // Compare the outputs that are defined for the cycle, leaving execution_empty_out free.
  task automatic chk_sn(input string tag, input logic [1:0] st, input logic stall,
                        input logic nop);
    #1;
    check({tag, ".state"}, 32'(state_out), 32'(st));
    check({tag, ".stall"}, 32'(stall_out), 32'(stall));
    check({tag, ".nop"},   32'(set_nop_out), 32'(nop));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid     = 1'b0;
    dec_src1      = 5'd0;
    dec_src2      = 5'd0;
    dec_uses_src1 = 1'b0;
    dec_uses_src2 = 1'b0;
    dec_is_mul    = 1'b0;
    ex_dst_reg    = 5'd0;
    ex_is_load    = 1'b0;
    mem_stall_in  = 1'b0;
    branch_taken  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();

    // Reset asserted: NOP forced, no stall.
    #2;
    chk_outs("reset", 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    chk_outs("idle", 2'd0, 1'b0, 1'b0, 1'b1);

    // Load r3 in execute, decode reads r3 via src2.
    tick();
    dec_valid = 1'b1; dec_uses_src2 = 1'b1; dec_src2 = 5'd3;
    ex_is_load = 1'b1; ex_dst_reg = 5'd3;
    chk_sn("hz_src2", 2'd0, 1'b1, 1'b1);
    tick();
    ex_is_load = 1'b0; ex_dst_reg = 5'd0;
    chk_outs("hz_after", 2'd0, 1'b0, 1'b0, 1'b1);

    // Load r0 read by decode: no hazard.
    tick();
    idle_inputs();
    dec_valid = 1'b1; dec_uses_src1 = 1'b1; dec_src1 = 5'd0;
    ex_is_load = 1'b1; ex_dst_reg = 5'd0;
    chk_outs("hz_r0", 2'd0, 1'b0, 1'b0, 1'b1);

    // Matching index but source not used: no hazard.
    dec_src1 = 5'd7; dec_uses_src1 = 1'b0; ex_dst_reg = 5'd7;
    chk_outs("hz_unused", 2'd0, 1'b0, 1'b0, 1'b1);

    // Matching src1 with dec_valid low: no hazard.
    dec_uses_src1 = 1'b1; dec_valid = 1'b0;
    chk_outs("hz_novalid", 2'd0, 1'b0, 1'b0, 1'b1);

    // Hazard together with multiply: hazard wins, state stays RUN.
    dec_valid = 1'b1; dec_is_mul = 1'b1;
    chk_sn("hz_mul", 2'd0, 1'b1, 1'b1);
    tick();
    check("hz_mul_stay", 32'(state_out), 32'd0);

    // Hazard together with branch: branch wins.
    branch_taken = 1'b1;
    chk_sn("br_over_hz", 2'd0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    chk_outs("br_over_hz_flush", 2'd3, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("br_over_hz_run", 2'd0, 1'b0, 1'b0, 1'b1);

    // Multiply issue: four MUL cycles of stall, then RUN.
    dec_valid = 1'b1; dec_is_mul = 1'b1;
    chk_outs("mul_issue", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_inputs();
      // The branch is ignored while the multiply occupies execute.
      if (i == 1) branch_taken = 1'b1;
      chk_outs($sformatf("mul_c%0d", i), 2'd1, 1'b1, 1'b0, 1'b0);
    end
    tick();
    idle_inputs();
    chk_outs("mul_done", 2'd0, 1'b0, 1'b0, 1'b1);

    // Multiply with a two-cycle cache miss: stall lasts six cycles.
    dec_valid = 1'b1; dec_is_mul = 1'b1;
    chk_outs("mulm_issue", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      idle_inputs();
      if (i == 1 || i == 2) mem_stall_in = 1'b1;
      chk_outs($sformatf("mulm_c%0d", i), 2'd1, 1'b1, 1'b0, 1'b0);
    end
    tick();
    idle_inputs();
    chk_outs("mulm_done", 2'd0, 1'b0, 1'b0, 1'b1);

    // Branch in RUN: NOP for two cycles, state 0 -> 3 -> 0.
    branch_taken = 1'b1;
    chk_sn("br_run", 2'd0, 1'b0, 1'b1);
    tick();
    branch_taken = 1'b0;
    chk_outs("br_flush", 2'd3, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("br_back", 2'd0, 1'b0, 1'b0, 1'b1);

    // Cache miss and branch together: MEM first, then the held branch flushes.
    mem_stall_in = 1'b1; branch_taken = 1'b1;
    chk_outs("mb_run", 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_outs("mb_mem0", 2'd2, 1'b1, 1'b0, 1'b0);
    tick();
    mem_stall_in = 1'b0;
    chk_outs("mb_mem1", 2'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk_sn("mb_run_br", 2'd0, 1'b0, 1'b1);
    tick();
    branch_taken = 1'b0;
    chk_outs("mb_flush", 2'd3, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("mb_back", 2'd0, 1'b0, 1'b0, 1'b1);

    // Cache miss during FLUSH holds FLUSH with stall only.
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0; mem_stall_in = 1'b1;
    chk_outs("fm_hold0", 2'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk_outs("fm_hold1", 2'd3, 1'b1, 1'b0, 1'b0);
    mem_stall_in = 1'b0;
    chk_outs("fm_release", 2'd3, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("fm_back", 2'd0, 1'b0, 1'b0, 1'b1);

    // Reset during a multiply with the counter at 3, between clock edges.
    dec_valid = 1'b1; dec_is_mul = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk_outs("rm_mul", 2'd1, 1'b1, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    chk_outs("rm_async", 2'd0, 1'b0, 1'b1, 1'b1);
    #1;
    rst_n = 1'b1;
    chk_outs("rm_release", 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_outs("rm_run", 2'd0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run so that a stuck simulation still ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
